ifu_line_fill_rsp: RTL and testbench

//  Memory-side responder for IFU instruction-cache line fills. Accepts a miss request (line tag)

---
 rtl/ifu_line_fill_rsp.sv | 109 ++++++++++
 tb/tb_ifu_line_fill_rsp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_line_fill_rsp.sv
// IFU line-fill responder: takes a missed line tag, streams NUM_WORDS sequential
// word reads to instruction memory, assembles the line and hands it back with the tag.
module ifu_line_fill_rsp #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TAG_WIDTH      = 27,
    parameter int LINE_WIDTH     = 128,
    parameter int WORD_WIDTH     = 32,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  FillReqValid,
    output logic                  FillReqReady,
    input  logic [TAG_WIDTH-1:0]  FillReqTag,
    output logic                  FillRspValid,
    input  logic                  FillRspReady,
    output logic [TAG_WIDTH-1:0]  FillRspTag,
    output logic [LINE_WIDTH-1:0] FillRspLine,
    output logic                  MemRdEn,
    output logic [ADDR_WIDTH-1:0] MemRdAddr,
    input  logic [WORD_WIDTH-1:0] MemRdData
);

    localparam int NUM_WORDS  = LINE_WIDTH / WORD_WIDTH;
    localparam int WORD_BYTES = WORD_WIDTH / 8;
    localparam int OFF_W      = ADDR_WIDTH - TAG_WIDTH;
    localparam int CNT_W      = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        issue_cnt;
    logic [CNT_W-1:0]        cap_cnt;
    logic [MEM_RD_LATENCY:1] vld_pipe;
    logic [ADDR_WIDTH-1:0]   base;
    logic                    cap;
    logic                    cap_last;

    // Latched tag doubles as the line base for the remaining issues
    assign base     = {FillRspTag, {OFF_W{1'b0}}};
    assign cap      = vld_pipe[MEM_RD_LATENCY];
    assign cap_last = cap && (cap_cnt == CNT_W'(NUM_WORDS - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            FillReqReady <= 1'b1;
            FillRspValid <= 1'b0;
            FillRspTag   <= '0;
            FillRspLine  <= '0;
            MemRdEn      <= 1'b0;
            MemRdAddr    <= '0;
            issue_cnt    <= '0;
            cap_cnt      <= '0;
            vld_pipe     <= '0;
        end else begin
            // vld_pipe[k] marks a read issued k cycles ago; the last stage lines up with MemRdData
            vld_pipe[1] <= MemRdEn;
            for (int i = 2; i <= MEM_RD_LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];

            if (cap) begin
                cap_cnt <= cap_cnt + CNT_W'(1);
                for (int i = 0; i < NUM_WORDS; i++)
                    if (cap_cnt == CNT_W'(i))
                        FillRspLine[i*WORD_WIDTH +: WORD_WIDTH] <= MemRdData;
            end

            case (state)
                IDLE: begin
                    if (FillReqValid) begin
                        FillRspTag   <= FillReqTag;
                        FillRspLine  <= '0;
                        FillReqReady <= 1'b0;
                        MemRdEn      <= 1'b1;
                        MemRdAddr    <= {FillReqTag, {OFF_W{1'b0}}};
                        issue_cnt    <= CNT_W'(1);
                        cap_cnt      <= '0;
                        state        <= READ;
                    end
                end
                READ: begin
                    if (issue_cnt == CNT_W'(NUM_WORDS)) begin
                        MemRdEn <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        MemRdAddr <= base + ADDR_WIDTH'(issue_cnt) * ADDR_WIDTH'(WORD_BYTES);
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (cap_last) begin
                        FillRspValid <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (FillRspReady) begin
                        FillRspValid <= 1'b0;
                        FillReqReady <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_line_fill_rsp.sv
// Bench for ifu_line_fill_rsp: a latency-1 and a latency-3 instance, each fed by a
// pipelined memory model whose word at address a is a ^ salt.
module tb_ifu_line_fill_rsp;

    localparam int NW = 4;
    localparam int L1 = 1;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic         Rst;
    logic         req_v, req_rdy, rsp_v, rsp_rdy, rd_en;
    logic [26:0]  req_tag, rsp_tag;
    logic [127:0] rsp_line;
    logic [31:0]  rd_addr, rd_data;

    logic         req_v3, req_rdy3, rsp_v3, rsp_rdy3, rd_en3;
    logic [26:0]  req_tag3, rsp_tag3;
    logic [127:0] rsp_line3;
    logic [31:0]  rd_addr3, rd_data3;

    int tests = 0;
    int fails = 0;
    logic [31:0] salt = '0;

    ifu_line_fill_rsp u_dut (
        .Clk(Clk), .Rst(Rst),
        .FillReqValid(req_v), .FillReqReady(req_rdy), .FillReqTag(req_tag),
        .FillRspValid(rsp_v), .FillRspReady(rsp_rdy), .FillRspTag(rsp_tag), .FillRspLine(rsp_line),
        .MemRdEn(rd_en), .MemRdAddr(rd_addr), .MemRdData(rd_data)
    );

    ifu_line_fill_rsp #(.MEM_RD_LATENCY(3)) u_dut3 (
        .Clk(Clk), .Rst(Rst),
        .FillReqValid(req_v3), .FillReqReady(req_rdy3), .FillReqTag(req_tag3),
        .FillRspValid(rsp_v3), .FillRspReady(rsp_rdy3), .FillRspTag(rsp_tag3), .FillRspLine(rsp_line3),
        .MemRdEn(rd_en3), .MemRdAddr(rd_addr3), .MemRdData(rd_data3)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ salt;
    endfunction

    function automatic logic [127:0] line_of(input logic [26:0] tag);
        logic [127:0] l;
        logic [31:0]  b;
        b = {tag, 5'b0};
        for (int i = 0; i < NW; i++) l[i*32 +: 32] = memf(b + 32'(i * 4));
        return l;
    endfunction

    // Memory: data for an enabled read appears LAT cycles later; junk otherwise
    logic [31:0] mq1;
    logic [31:0] mq3 [3];
    always @(posedge Clk) begin
        mq1    <= rd_en ? memf(rd_addr) : $urandom;
        mq3[0] <= rd_en3 ? memf(rd_addr3) : $urandom;
        mq3[1] <= mq3[0];
        mq3[2] <= mq3[1];
    end
    assign rd_data  = mq1;
    assign rd_data3 = mq3[2];

    // Starts at a negedge; request accepted in cycle 0, response held 'hold' extra cycles
    task automatic run_req(input logic [26:0] tag, input int hold, input logic busy_v,
                           input logic [26:0] busy_tag, input string nm);
        logic [31:0]  b;
        logic [127:0] el;
        int           n, t_rsp;
        b     = {tag, 5'b0};
        el    = line_of(tag);
        t_rsp = NW + L1 + 1;
        n     = 0;
        while (req_rdy !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
        tests++;
        if (req_rdy !== 1'b1) begin fails++; $display("FAIL %s idle_ready got %b want 1", nm, req_rdy); end
        req_v = 1'b1; req_tag = tag; rsp_rdy = 1'b0;
        for (int t = 1; t <= t_rsp + hold; t++) begin
            @(negedge Clk);
            if (t == 1) begin req_v = busy_v; req_tag = busy_tag; end
            tests++;
            if (rd_en !== (t <= NW)) begin
                fails++; $display("FAIL %s rd_en c%0d got %b want %b", nm, t, rd_en, (t <= NW));
            end
            if (t <= NW) begin
                tests++;
                if (rd_addr !== b + 32'((t - 1) * 4)) begin
                    fails++; $display("FAIL %s rd_addr c%0d got %h want %h", nm, t, rd_addr, b + 32'((t - 1) * 4));
                end
            end
            tests++;
            if (rsp_v !== (t >= t_rsp) || req_rdy !== 1'b0) begin
                fails++; $display("FAIL %s valid/ready c%0d got %b/%b want %b/0", nm, t, rsp_v, req_rdy, (t >= t_rsp));
            end
            if (t >= t_rsp) begin
                tests++;
                if (rsp_tag !== tag || rsp_line !== el) begin
                    fails++; $display("FAIL %s rsp c%0d got %h/%h want %h/%h", nm, t, rsp_tag, rsp_line, tag, el);
                end
            end
            if (t == t_rsp + hold) rsp_rdy = 1'b1;
        end
        @(negedge Clk);
        rsp_rdy = 1'b0; req_v = 1'b0;
        tests++;
        if (rsp_v !== 1'b0 || req_rdy !== 1'b1) begin
            fails++; $display("FAIL %s after_hs got valid %b ready %b want 0 1", nm, rsp_v, req_rdy);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; req_v = 0; req_tag = '0; rsp_rdy = 0;
        req_v3 = 0; req_tag3 = '0; rsp_rdy3 = 0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        tests++;
        if (req_rdy !== 1'b1 || rsp_v !== 1'b0 || rd_en !== 1'b0 || rd_addr !== '0 ||
            rsp_tag !== '0 || rsp_line !== '0) begin
            fails++; $display("FAIL reset got rdy %b v %b en %b addr %h tag %h line %h",
                              req_rdy, rsp_v, rd_en, rd_addr, rsp_tag, rsp_line);
        end
        @(negedge Clk);
        tests++;
        if (req_rdy !== 1'b1 || rsp_v !== 1'b0 || rd_en !== 1'b0) begin
            fails++; $display("FAIL reset_idle got rdy %b v %b en %b", req_rdy, rsp_v, rd_en);
        end
    endtask

    task automatic test_basic();
        salt = '0;
        run_req(27'h0000010, 0, 1'b0, '0, "basic");
    endtask

    task automatic test_backpressure();
        salt = 32'hA5A5_0F0F;
        run_req(27'h0123456, 5, 1'b0, '0, "backpressure");
    endtask

    task automatic test_back_to_back();
        salt = 32'h1357_9BDF;
        run_req(27'h0000ABC, 0, 1'b1, 27'h1, "busy_first");
        req_v = 1'b1; req_tag = 27'h1;
        run_req(27'h1, 0, 1'b0, '0, "busy_second");
    endtask

    task automatic test_top_tag();
        salt = '0;
        run_req(27'h7FFFFFF, 1, 1'b0, '0, "top_tag");
    endtask

    task automatic test_reset_mid();
        salt = 32'hDEAD_0000;
        req_v = 1'b1; req_tag = 27'h0000123;
        @(negedge Clk);
        req_v = 1'b0;
        @(negedge Clk);
        tests++;
        if (rd_en !== 1'b1) begin fails++; $display("FAIL rst_mid issuing got %b want 1", rd_en); end
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        tests++;
        if (req_rdy !== 1'b1 || rsp_v !== 1'b0 || rd_en !== 1'b0 || rsp_tag !== '0 || rsp_line !== '0) begin
            fails++; $display("FAIL rst_mid got rdy %b v %b en %b tag %h line %h",
                              req_rdy, rsp_v, rd_en, rsp_tag, rsp_line);
        end
        salt = 32'h0BAD_F00D;
        run_req(27'h0000456, 0, 1'b0, '0, "rst_mid_clean");
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            salt = $urandom;
            run_req(27'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    27'($urandom), "random");
        end
    endtask

    task automatic test_latency3();
        int t_seen;
        logic [127:0] el;
        salt   = '0;
        el     = line_of(27'h10);
        t_seen = -1;
        req_v3 = 1'b1; req_tag3 = 27'h10; rsp_rdy3 = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            @(negedge Clk);
            if (t == 1) begin
                req_v3 = 1'b0;
                tests++;
                if (rd_en3 !== 1'b1 || rd_addr3 !== 32'h200) begin
                    fails++; $display("FAIL lat3 first_rd got %b/%h want 1/00000200", rd_en3, rd_addr3);
                end
            end
            if (rsp_v3 === 1'b1) begin t_seen = t; break; end
        end
        tests++;
        if (t_seen != 8) begin fails++; $display("FAIL lat3 cycle got %0d want 8", t_seen); end
        tests++;
        if (rsp_line3 !== el || rsp_tag3 !== 27'h10) begin
            fails++; $display("FAIL lat3 rsp got %h/%h want %h/%h", rsp_tag3, rsp_line3, 27'h10, el);
        end
        @(negedge Clk);
        rsp_rdy3 = 1'b0;
        tests++;
        if (rsp_v3 !== 1'b0 || req_rdy3 !== 1'b1) begin
            fails++; $display("FAIL lat3 after_hs got %b/%b want 0/1", rsp_v3, req_rdy3);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_top_tag();
        test_reset_mid();
        test_random();
        test_latency3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
